// File: rtl/in_service_controller_if.sv
// rtl/in_service_controller_if.sv - request/acknowledge/EOI bundle of the in-service controller
//
// Purpose: groups the IRR/IMR inputs, CPU INTA/EOI strobes and the INT/vector
// outputs of the in-service controller.
// Modports:
//   master - upstream side: drives requests, mask, vector base, strobes; sees INT/ISR/vector.
//   slave  - controller side: the reverse.
interface in_service_controller_if;
    logic [7:0] interruptRequest;
    logic [7:0] interruptMask;
    logic [4:0] vectorBase;
    logic       autoEoi;
    logic       intaStrobe;
    logic       eoiStrobe;
    logic       eoiSpecific;
    logic [2:0] eoiLevel;
    logic       intOut;
    logic [7:0] clearInterruptRequest;
    logic [7:0] inService;
    logic [7:0] vectorOut;
    logic       vectorValid;

    modport master (
        output interruptRequest, interruptMask, vectorBase, autoEoi,
               intaStrobe, eoiStrobe, eoiSpecific, eoiLevel,
        input  intOut, clearInterruptRequest, inService, vectorOut, vectorValid
    );

    modport slave (
        input  interruptRequest, interruptMask, vectorBase, autoEoi,
               intaStrobe, eoiStrobe, eoiSpecific, eoiLevel,
        output intOut, clearInterruptRequest, inService, vectorOut, vectorValid
    );
endinterface

// File: rtl/in_service_controller.sv
// rtl/in_service_controller.sv - 8-level fully nested in-service register and INTA sequencer
//
// Purpose: prioritises unmasked requests against the in-service register,
// raises INT, runs the two-pulse INTA handshake (ISR set + IRR clear on the
// first pulse, vector on the second) and services normal, specific and
// automatic EOI. IR0 is highest priority.
// Ports:
//   clk    - system clock, rising edge
//   resetN - synchronous active-low reset
//   bus    - in_service_controller_if.slave (requests, mask, strobes, INT, ISR, vector)
module in_service_controller (
    input logic                    clk,
    input logic                    resetN,
    in_service_controller_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT2 = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       int_q, int_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] clr_q, clr_d;
    logic [7:0] vec_q, vec_d;
    logic       vv_q, vv_d;
    logic [2:0] lvl_q, lvl_d;
    logic       spur_q, spur_d;

    logic [7:0] pending;
    logic       pending_any;
    logic [2:0] p_lvl;
    logic [3:0] s_lvl;
    logic [7:0] isr_set;
    logic [7:0] aeoi_clr;
    logic [7:0] eoi_clr;

    assign pending     = bus.interruptRequest & ~bus.interruptMask;
    assign pending_any = |pending;

    // Lowest set index wins; scanning downward lets the lowest index overwrite.
    always_comb begin
        p_lvl = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) p_lvl = 3'(i);
        end
    end

    // s_lvl is 8 when nothing is in service so any pending level outranks it.
    always_comb begin
        s_lvl = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (isr_q[i]) s_lvl = 4'(i);
        end
    end

    always_comb begin
        eoi_clr = 8'd0;
        if (bus.eoiStrobe) begin
            if (bus.eoiSpecific) begin
                eoi_clr = 8'(1) << bus.eoiLevel;
            end else if (!s_lvl[3]) begin
                eoi_clr = 8'(1) << s_lvl[2:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        int_d    = 1'b0;
        clr_d    = 8'd0;
        vec_d    = vec_q;
        vv_d     = 1'b0;
        lvl_d    = lvl_q;
        spur_d   = spur_q;
        isr_set  = 8'd0;
        aeoi_clr = 8'd0;

        case (state_q)
            IDLE: begin
                if (bus.intaStrobe && int_q) begin
                    state_d = WAIT2;
                    if (pending_any) begin
                        lvl_d   = p_lvl;
                        spur_d  = 1'b0;
                        isr_set = 8'(1) << p_lvl;
                        clr_d   = 8'(1) << p_lvl;
                    end else begin
                        // Request withdrawn between INT and INTA: report IR7, touch nothing.
                        lvl_d  = 3'd7;
                        spur_d = 1'b1;
                    end
                end else begin
                    int_d = pending_any && ({1'b0, p_lvl} < s_lvl);
                end
            end
            WAIT2: begin
                if (bus.intaStrobe) begin
                    vec_d   = {bus.vectorBase, lvl_q};
                    vv_d    = 1'b1;
                    state_d = DONE;
                    if (bus.autoEoi && !spur_q) aeoi_clr = 8'(1) << lvl_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A set on the same edge as a clear of that bit must survive.
        isr_d = (isr_q & ~(eoi_clr | aeoi_clr)) | isr_set;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= IDLE;
            int_q   <= 1'b0;
            isr_q   <= 8'd0;
            clr_q   <= 8'd0;
            vec_q   <= 8'd0;
            vv_q    <= 1'b0;
            lvl_q   <= 3'd0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
            isr_q   <= isr_d;
            clr_q   <= clr_d;
            vec_q   <= vec_d;
            vv_q    <= vv_d;
            lvl_q   <= lvl_d;
            spur_q  <= spur_d;
        end
    end

    assign bus.intOut                = int_q;
    assign bus.clearInterruptRequest = clr_q;
    assign bus.inService             = isr_q;
    assign bus.vectorOut             = vec_q;
    assign bus.vectorValid           = vv_q;

endmodule

// File: tb/tb_in_service_controller.sv
// tb/tb_in_service_controller.sv - directed self-checking bench for in_service_controller
module tb_in_service_controller;

    logic clk;
    logic resetN;
    int   checks;
    int   failures;

    in_service_controller_if bus ();

    in_service_controller dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic inta();
        bus.intaStrobe = 1'b1;
        step();
        bus.intaStrobe = 1'b0;
    endtask

    task automatic eoi(input logic specific, input logic [2:0] level);
        bus.eoiStrobe   = 1'b1;
        bus.eoiSpecific = specific;
        bus.eoiLevel    = level;
        step();
        bus.eoiStrobe   = 1'b0;
        bus.eoiSpecific = 1'b0;
        bus.eoiLevel    = 3'd0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetN   = 1'b0;
        bus.interruptRequest = 8'h00;
        bus.interruptMask    = 8'h00;
        bus.vectorBase       = 5'h11;
        bus.autoEoi          = 1'b0;
        bus.intaStrobe       = 1'b0;
        bus.eoiStrobe        = 1'b0;
        bus.eoiSpecific      = 1'b0;
        bus.eoiLevel         = 3'd0;
        step();
        step();
        chk("rst_isr", bus.inService, 8'h00);
        chk("rst_int", {7'd0, bus.intOut}, 8'h00);
        chk("rst_clr", bus.clearInterruptRequest, 8'h00);
        chk("rst_vec", bus.vectorOut, 8'h00);
        chk("rst_vv", {7'd0, bus.vectorValid}, 8'h00);
        resetN = 1'b1;

        // Simple acknowledge on IR3, mask flipped during WAIT2
        bus.interruptRequest = 8'h08;
        step();
        chk("ack_int", {7'd0, bus.intOut}, 8'h01);
        inta();
        chk("ack_clr", bus.clearInterruptRequest, 8'h08);
        chk("ack_isr", bus.inService, 8'h08);
        chk("ack_int_low", {7'd0, bus.intOut}, 8'h00);
        bus.interruptRequest = 8'h00;
        bus.interruptMask    = 8'hFF;
        inta();
        chk("ack_vec", bus.vectorOut, 8'h8B);
        chk("ack_vv", {7'd0, bus.vectorValid}, 8'h01);
        step();
        chk("ack_vv_pulse", {7'd0, bus.vectorValid}, 8'h00);
        chk("ack_clr_pulse", bus.clearInterruptRequest, 8'h00);
        bus.interruptMask = 8'h00;

        // Nesting: IR5 blocked by IR3 in service, IR1 preempts
        bus.interruptRequest = 8'h20;
        step();
        step();
        chk("nest_blocked", {7'd0, bus.intOut}, 8'h00);
        bus.interruptRequest = 8'h22;
        step();
        chk("nest_int", {7'd0, bus.intOut}, 8'h01);
        inta();
        chk("nest_isr", bus.inService, 8'h0A);
        chk("nest_clr", bus.clearInterruptRequest, 8'h02);
        bus.interruptRequest = 8'h00;
        inta();
        chk("nest_vec", bus.vectorOut, 8'h89);
        step();
        eoi(1'b0, 3'd0);
        chk("nest_eoi1", bus.inService, 8'h08);
        eoi(1'b0, 3'd0);
        chk("nest_eoi2", bus.inService, 8'h00);

        // Masking and spurious
        bus.interruptRequest = 8'h01;
        bus.interruptMask    = 8'h01;
        step();
        chk("mask_int", {7'd0, bus.intOut}, 8'h00);
        bus.interruptMask = 8'h00;
        step();
        chk("unmask_int", {7'd0, bus.intOut}, 8'h01);
        bus.interruptRequest = 8'h00;
        inta();
        chk("spur_isr", bus.inService, 8'h00);
        chk("spur_clr", bus.clearInterruptRequest, 8'h00);
        inta();
        chk("spur_vec", bus.vectorOut, 8'h8F);
        chk("spur_vv", {7'd0, bus.vectorValid}, 8'h01);
        step();

        // Set beats a same-bit EOI clear on the same edge
        bus.interruptRequest = 8'h01;
        step();
        bus.intaStrobe  = 1'b1;
        bus.eoiStrobe   = 1'b1;
        bus.eoiSpecific = 1'b1;
        bus.eoiLevel    = 3'd0;
        step();
        bus.intaStrobe  = 1'b0;
        bus.eoiStrobe   = 1'b0;
        bus.eoiSpecific = 1'b0;
        chk("setwin_isr", bus.inService, 8'h01);
        bus.interruptRequest = 8'h00;
        inta();
        chk("setwin_vec", bus.vectorOut, 8'h88);
        step();
        eoi(1'b0, 3'd0);
        chk("setwin_eoi", bus.inService, 8'h00);

        // Build ISR=0x14, then EOI variants
        bus.interruptRequest = 8'h10;
        step();
        inta();
        bus.interruptRequest = 8'h00;
        inta();
        step();
        bus.interruptRequest = 8'h04;
        step();
        chk("eoi_nest_int", {7'd0, bus.intOut}, 8'h01);
        inta();
        chk("eoi_isr14", bus.inService, 8'h14);
        bus.interruptRequest = 8'h00;
        inta();
        step();
        eoi(1'b0, 3'd0);
        chk("eoi_nonspec", bus.inService, 8'h10);
        eoi(1'b1, 3'd2);
        chk("eoi_spec_noop", bus.inService, 8'h10);
        eoi(1'b1, 3'd4);
        chk("eoi_spec4", bus.inService, 8'h00);

        // Automatic EOI on IR5
        bus.autoEoi          = 1'b1;
        bus.interruptRequest = 8'h20;
        step();
        inta();
        chk("aeoi_isr1", bus.inService, 8'h20);
        bus.interruptRequest = 8'h00;
        inta();
        chk("aeoi_isr2", bus.inService, 8'h00);
        chk("aeoi_vec", bus.vectorOut, 8'h8D);
        step();
        bus.autoEoi = 1'b0;

        // Reset in WAIT2
        bus.interruptRequest = 8'h04;
        step();
        inta();
        chk("rstw_isr_pre", bus.inService, 8'h04);
        bus.interruptRequest = 8'h00;
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        chk("rstw_isr", bus.inService, 8'h00);
        chk("rstw_int", {7'd0, bus.intOut}, 8'h00);
        chk("rstw_clr", bus.clearInterruptRequest, 8'h00);
        chk("rstw_vec", bus.vectorOut, 8'h00);
        chk("rstw_vv", {7'd0, bus.vectorValid}, 8'h00);
        inta();
        chk("rstw_inta2_vv", {7'd0, bus.vectorValid}, 8'h00);
        chk("rstw_inta2_isr", bus.inService, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/in_service_controller.md
IN_SERVICE_CONTROLLER -- requirements
Module: in_service_controller

Interface
REQ-001 Parameters: none. The block is fixed at 8 interrupt levels, IR0 highest priority and IR7 lowest.
REQ-002 clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 resetN  in  1  reset, synchronous, active-low.
REQ-004 interruptRequest  in  8  latched requests from the upstream IRR stage.
REQ-005 interruptMask  in  8  IMR; a 1 masks that level.
REQ-006 vectorBase  in  5  ICW2 T7..T3.
REQ-007 autoEoi  in  1  1 selects automatic EOI at the end of the second INTA.
REQ-008 intaStrobe  in  1  one-cycle pulse per CPU INTA pulse, already edge-detected.
REQ-009 eoiStrobe  in  1  one-cycle EOI command pulse.
REQ-010 eoiSpecific  in  1  qualifies eoiStrobe: 1 = specific EOI, 0 = non-specific EOI.
REQ-011 eoiLevel  in  3  level to clear on a specific EOI.
REQ-012 intOut  out  1  INT request to the CPU; registered.
REQ-013 clearInterruptRequest  out  8  one-cycle clear pulse to the IRR; one-hot or zero.
REQ-014 inService  out  8  ISR contents; registered.
REQ-015 vectorOut  out  8  interrupt vector; valid only while vectorValid=1.
REQ-016 vectorValid  out  1  one-cycle qualifier for vectorOut.

Function
REQ-017 pending SHALL equal interruptRequest AND NOT interruptMask, evaluated every cycle.
REQ-018 pLvl SHALL be the lowest set index in pending; sLvl SHALL be the lowest set index in inService, or 8 when inService is zero.
REQ-019 The FSM SHALL have exactly three states: IDLE, WAIT2 and DONE.
REQ-020 In IDLE, intOut SHALL be set on the next edge when pending is nonzero and pLvl < sLvl (fully nested mode), and SHALL otherwise be cleared.
REQ-021 An intaStrobe in IDLE with intOut=0 SHALL be ignored.
REQ-022 An intaStrobe in IDLE with intOut=1 (first INTA) SHALL, on the same edge:
- latch lvl = pLvl as recomputed in that cycle;
- set inService[lvl];
- drive clearInterruptRequest[lvl]=1 for exactly one cycle;
- clear intOut;
- move to WAIT2.
REQ-023 If pending is zero at the first INTA (the request was withdrawn), the FSM SHALL:
- latch lvl=7 as a spurious interrupt;
- leave inService unchanged;
- drive clearInterruptRequest=0.
REQ-024 In WAIT2, intOut SHALL stay 0 and new requests SHALL only be evaluated after the return to IDLE.
REQ-025 An intaStrobe in WAIT2 (second INTA) SHALL, on the same edge:
- drive vectorOut={vectorBase,lvl} with vectorValid=1 for exactly one cycle;
- clear inService[lvl] if autoEoi=1 and the cycle was not spurious;
- move to DONE.
REQ-026 DONE SHALL return to IDLE unconditionally on the next edge; intOut SHALL NOT be asserted in DONE.
REQ-027 A non-specific EOI (eoiStrobe=1, eoiSpecific=0) SHALL clear inService[sLvl], and SHALL have no effect when inService is zero.
REQ-028 A specific EOI (eoiStrobe=1, eoiSpecific=1) SHALL clear inService[eoiLevel], and SHALL be a no-op when that bit is already 0.
REQ-029 EOI SHALL be accepted in every state.
REQ-030 When an EOI clear and an ISR set hit the same bit on the same edge, the set SHALL win; when they hit different bits, both SHALL take effect.
REQ-031 Latency: from a pending change to intOut is 1 cycle; from the first INTA to the IRR clear pulse is 0 cycles (same edge); from the second INTA to vectorValid is 0 cycles.
REQ-032 Mask changes while in WAIT2 SHALL NOT alter the latched lvl.

Reset
REQ-033 With resetN=0 at a rising edge, the block SHALL:
- move the FSM to IDLE;
- drive inService, clearInterruptRequest and vectorOut to 0x00;
- drive intOut and vectorValid to 0;
- set lvl to 0.
REQ-034 Reset SHALL override every other input, including a reset asserted mid-handshake in WAIT2; after reset, a second intaStrobe SHALL be ignored.

Verification
REQ-035 Simple acknowledge: interruptRequest=0x08, mask=0x00, vectorBase=0x11 -> intOut=1 after 1 cycle; INTA1 -> clearInterruptRequest=0x08 and inService=0x08; INTA2 -> vectorOut=0x8B.
REQ-036 Priority and nesting:
- with inService=0x08 and interruptRequest=0x20 -> intOut stays 0;
- raise interruptRequest to 0x22 -> intOut=1 and INTA1 sets inService to 0x0A.
REQ-037 Masking and spurious:
- interruptRequest=0x01 with mask=0x01 -> intOut=0;
- unmasked request withdrawn before INTA1 -> inService unchanged and the vector LSBs are 111.
REQ-038 EOI:
- inService=0x14, non-specific EOI -> 0x10;
- then specific EOI with eoiLevel=2 -> 0x10 unchanged;
- then specific EOI with eoiLevel=4 -> 0x00.
REQ-039 AEOI: autoEoi=1 with request on IR5 -> inService=0x20 after INTA1 and 0x00 after INTA2.
REQ-040 Reset in WAIT2: resetN=0 for 1 cycle -> all outputs 0, FSM in IDLE, and a following intaStrobe produces vectorValid=0.
